// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS-232 transmitter.
package rs232_pkg;

  localparam int DEFAULT_BAUD_DIV = 434;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } state_e;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rs232_tx_if.sv
// Host-side bundle of the transmitter: byte write port, buffer flags and serial line.
interface rs232_tx_if;
  import rs232_pkg::*;

  logic [DATA_BITS-1:0] data;
  logic                 we;
  logic                 full;
  logic                 empty;
  logic                 busy;
  logic                 tx;

  modport master (output data, we, input full, empty, busy, tx);
  modport slave  (input data, we, output full, empty, busy, tx);

endinterface

// File: rtl/rs232_tx_fifo.sv
// Byte FIFO feeding the transmitter; head byte is visible on q without a read cycle.
module rs232_tx_fifo
  import rs232_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [DATA_BITS-1:0] data,
  input  logic                 we,
  input  logic                 pop,
  output logic [DATA_BITS-1:0] q,
  output logic                 full,
  output logic                 empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          count_q, count_d;
  logic                 wr_ok, rd_ok;

  assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign empty = (count_q == '0);
  assign q     = mem[rd_ptr_q];

  // Pointers are exactly AW bits wide, so wrap-around is the natural overflow.
  always_comb begin
    wr_ok    = we & ~full;
    rd_ok    = pop & ~empty;
    wr_ptr_d = wr_ptr_q + AW'(wr_ok);
    rd_ptr_d = rd_ptr_q + AW'(rd_ok);
    count_d  = count_q + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr_q] <= data;
    end
  end

endmodule

// File: rtl/rs232_tx.sv
// Buffered 8N1 UART transmitter; define RS232_TX_PARITY_EN for an even-parity bit (8E1).
module rs232_tx
  import rs232_pkg::*;
#(
  parameter int BAUD_DIV   = DEFAULT_BAUD_DIV,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  rs232_tx_if.slave  bus
);

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_BITS - 1);

  state_e               state_q, state_d;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 tx_q, tx_d;
  logic                 busy_q, busy_d;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_q;
  logic                 fifo_full, fifo_empty;
`ifdef RS232_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  rs232_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .data  (bus.data),
    .we    (bus.we),
    .pop   (pop),
    .q     (fifo_q),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign bus.full  = fifo_full;
  assign bus.empty = fifo_empty;
  assign bus.busy  = busy_q;
  assign bus.tx    = tx_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    tx_d    = tx_q;
    pop     = 1'b0;
`ifdef RS232_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        tx_d = 1'b1;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q;
          state_d = ST_START;
          tx_d    = 1'b0;
          cnt_d   = BAUD_LAST;
`ifdef RS232_TX_PARITY_EN
          par_d   = even_parity(fifo_q);
`endif
        end
      end
      ST_START: begin
        if (cnt_q == '0) begin
          state_d = ST_DATA;
          tx_d    = shift_q[0];
          idx_d   = '0;
          cnt_d   = BAUD_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      ST_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = BAUD_LAST;
          if (idx_q == LAST_BIT) begin
`ifdef RS232_TX_PARITY_EN
            state_d = ST_PARITY;
            tx_d    = par_q;
`else
            state_d = ST_STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            // shift_q[1] is the bit that becomes LSB after this shift
            idx_d   = idx_q + 3'd1;
            shift_d = shift_q >> 1;
            tx_d    = shift_q[1];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`ifdef RS232_TX_PARITY_EN
      ST_PARITY: begin
        if (cnt_q == '0) begin
          state_d = ST_STOP;
          tx_d    = 1'b1;
          cnt_d   = BAUD_LAST;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
`endif
      ST_STOP: begin
        if (cnt_q == '0) begin
          // A waiting byte starts its frame straight out of the stop bit.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_q;
            state_d = ST_START;
            tx_d    = 1'b0;
            cnt_d   = BAUD_LAST;
`ifdef RS232_TX_PARITY_EN
            par_d   = even_parity(fifo_q);
`endif
          end else begin
            state_d = ST_IDLE;
            tx_d    = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        tx_d    = 1'b1;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef RS232_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef RS232_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_rs232_tx.sv
// Randomised scoreboard bench for rs232_tx; frame-level model plus serial-line decoder.
module tb_rs232_tx;
  import rs232_pkg::*;

  localparam int BAUD  = 4;
  localparam int DEPTH = 16;
`ifdef RS232_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * BAUD;
  localparam int DRAIN_LIMIT = (DEPTH + 3) * FRAME + 50;

  logic clk = 1'b0;
  logic reset = 1'b0;

  rs232_tx_if bus ();

  rs232_tx #(.BAUD_DIV(BAUD), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int timeouts = 0;
  bit end_req = 0;
  bit end_done = 0;

  // Reference model state: values describe the DUT after the next rising edge.
  logic [7:0]       m_q[$];
  logic [7:0]       sb_q[$];
  int               m_cnt = 0;
  int               m_rem = 0;
  bit               m_active = 0;
  logic [NBITS-1:0] m_frame = '1;

  bit               mon_act = 0;
  int               mon_cnt = 0;
  int               frames_seen = 0;
  logic [NBITS-1:0] mon_bits = '1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [NBITS-1:0] mk_frame(input logic [7:0] b);
    logic [NBITS-1:0] f;
    f      = '1;
    f[0]   = 1'b0;
    f[8:1] = b;
`ifdef RS232_TX_PARITY_EN
    f[9]   = ^b;
`endif
    return f;
  endfunction

  // Checker: compare line/flags to the model, decode frames, then advance the model.
  always @(negedge clk) begin
    int bi;
    int b;
    bit acc;
    bit pp;
    logic [7:0] got;
    logic [7:0] exp_b;
    if (!reset) begin
      m_q.delete();
      sb_q.delete();
      m_cnt    = 0;
      m_rem    = 0;
      m_active = 0;
      mon_act  = 0;
    end
    bi = (FRAME - 1 - m_rem) / BAUD;
    check("tx",    32'(bus.tx),    32'(m_active ? m_frame[bi] : 1'b1));
    check("busy",  32'(bus.busy),  32'(m_active));
    check("full",  32'(bus.full),  32'(m_cnt == DEPTH));
    check("empty", 32'(bus.empty), 32'(m_cnt == 0));
    if (reset) begin
      if (mon_act) begin
        mon_cnt++;
        if (mon_cnt % BAUD == BAUD / 2) begin
          b = mon_cnt / BAUD;
          mon_bits[b] = bus.tx;
          if (b == NBITS - 1) begin
            mon_act = 0;
            got = mon_bits[8:1];
            check("start_bit", 32'(mon_bits[0]), 32'd0);
            check("stop_bit", 32'(mon_bits[NBITS-1]), 32'd1);
`ifdef RS232_TX_PARITY_EN
            check("parity_bit", 32'(mon_bits[9]), 32'(^got));
`endif
            if (sb_q.size() == 0) begin
              check("frame_unexpected", 32'(got), 32'hFFFF_FFFF);
            end else begin
              exp_b = sb_q.pop_front();
              check("frame_byte", 32'(got), 32'(exp_b));
              frames_seen++;
              $display("frame %0d byte=%02h expected=%02h", frames_seen, got, exp_b);
            end
          end
        end
      end else if (bus.tx == 1'b0) begin
        mon_act = 1;
        mon_cnt = 0;
      end

      acc = bus.we && (m_cnt < DEPTH);
      pp  = (m_rem == 0) && (m_cnt > 0);
      if (pp) begin
        m_frame  = mk_frame(m_q.pop_front());
        m_rem    = FRAME - 1;
        m_active = 1;
      end else if (m_rem > 0) begin
        m_rem--;
      end else begin
        m_active = 0;
      end
      if (acc) begin
        m_q.push_back(bus.data);
        sb_q.push_back(bus.data);
      end
      m_cnt = m_cnt + int'(acc) - int'(pp);
    end
    if (end_req && !end_done) begin
      check("timeouts", 32'(timeouts), 32'd0);
      check("sb_drained", 32'(sb_q.size()), 32'd0);
      end_done = 1;
    end
  end

  task automatic write_seq(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      @(posedge clk);
      #1;
      bus.we   = 1'b1;
      bus.data = bytes[i];
    end
    @(posedge clk);
    #1;
    bus.we = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (!(m_cnt == 0 && !m_active) && n < DRAIN_LIMIT) begin
      @(posedge clk);
      n++;
    end
    if (n >= DRAIN_LIMIT) timeouts++;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    logic [7:0] seq[$];
    int n;
    bus.we   = 1'b0;
    bus.data = 8'h00;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);

    seq = '{8'h55};
    write_seq(seq);
    drain();

    seq = '{8'hA5, 8'h3C};
    write_seq(seq);
    drain();

    seq.delete();
    for (int i = 0; i < 18; i++) seq.push_back(8'($urandom));
    write_seq(seq);
    drain();

    seq = '{8'h07};
    write_seq(seq);
    drain();
    seq = '{8'h03};
    write_seq(seq);
    drain();

    for (int i = 0; i < 500; i++) begin
      @(posedge clk);
      #1;
      bus.we   = ($urandom_range(0, 7) == 0);
      bus.data = 8'($urandom);
    end
    @(posedge clk);
    #1 bus.we = 1'b0;
    drain();

    // Abort a frame of 0xFF while data bit 3 is on the line.
    seq = '{8'hFF};
    write_seq(seq);
    n = 0;
    while (!(m_active && (FRAME - 1 - m_rem) / BAUD == 4) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) timeouts++;
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3 * FRAME) @(posedge clk);

    seq = '{8'h81, 8'h18};
    write_seq(seq);
    drain();

    end_req = 1;
    n = 0;
    while (!end_done && n < 10) begin
      @(posedge clk);
      n++;
    end
    if (!end_done) $display("FAIL end_check actual=pending required=done");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rs232_tx.md
RS232_TX -- requirements
Module: rs232_tx

Interface
REQ-001 Parameter: BAUD_DIV, default 434, clock cycles per serial bit (50 MHz / 115200); legal range 2..65535.
REQ-002 Parameter: FIFO_DEPTH, default 16, byte buffer entries; power of two, 2..256.
REQ-003 Port: clk  input  1  single system clock; all state on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: data  input  8  byte to transmit.
REQ-006 Port: we  input  1  write strobe; one byte per asserted cycle.
REQ-007 Port: full  output  1  buffer holds FIFO_DEPTH bytes.
REQ-008 Port: empty  output  1  buffer holds zero bytes.
REQ-009 Port: busy  output  1  a frame is being shifted out.
REQ-010 Port: tx  output  1  serial line, idle high, registered.

Function
REQ-011 Write accepted at an edge iff we=1 and full=0 at that edge; a write while full is dropped with no state change.
REQ-012 Buffer is FIFO order; occupancy counter of width log2(FIFO_DEPTH)+1; read/write pointers wrap modulo FIFO_DEPTH.
REQ-013 Simultaneous accepted write and pop leave occupancy unchanged.
REQ-014 FSM states: IDLE, START, DATA, STOP (plus PARITY, see REQ-024).
REQ-015 IDLE: tx=1, busy=0; at the first edge where empty=0, pop head byte into shift register, go to START, drive tx=0.
REQ-016 Byte written into an empty buffer while IDLE: tx falls at the next edge after the write edge (one-cycle latency).
REQ-017 Each bit (START, 8 DATA, STOP) lasts exactly BAUD_DIV cycles, timed by a down-counter loaded with BAUD_DIV-1 and advancing state at 0.
REQ-018 DATA shifts LSB first; 3-bit index counts 0..7, leaves DATA after bit 7.
REQ-019 STOP drives tx=1; at its end, if empty=0, pop and enter START directly (back-to-back frames, no idle gap); else enter IDLE.
REQ-020 busy=1 in every state except IDLE.
REQ-021 we and data are ignored for frame content once a byte is popped; buffer writes proceed during transmission.

Reset
REQ-022 reset=0 asynchronously forces: state IDLE, tx=1, busy=0, empty=1, full=0, pointers/counters 0, buffer contents discarded.
REQ-023 Reset mid-frame aborts the frame immediately; tx returns high without completing the stop bit.

Configuration
REQ-024 With RS232_TX_PARITY_EN defined: PARITY state between DATA and STOP, one bit of BAUD_DIV cycles, even parity (XOR of 8 data bits); frame = 11 bits.
REQ-025 Without RS232_TX_PARITY_EN: no PARITY state, frame = 10 bits (8N1); port list identical in both builds.

Structure
REQ-026 Package rs232_pkg holds: FSM state enum, default BAUD_DIV constant, DATA_BITS=8 constant.
REQ-027 Buffer is sub-module rs232_tx_fifo (data/we in, pop in, q/full/empty out); FSM and baud counter live in rs232_tx.

Verification (BAUD_DIV=4, FIFO_DEPTH=16 unless stated)
REQ-028 Reset then write 0x55 -> tx low 1 cycle after write edge; bit levels 0,1,0,1,0,1,0,1,0,1 each 4 cycles; then IDLE, busy=0.
REQ-029 Writes 0xA5 then 0x3C on consecutive cycles -> 80 cycles continuous busy=1, second start bit immediately after first stop bit, data LSB first.
REQ-030 18 writes on consecutive cycles starting IDLE -> first popped after 1 cycle, full=1 after write 17, write 18 dropped; 17 frames transmitted in order.
REQ-031 Assert reset during DATA bit 3 of 0xFF -> tx=1, busy=0, empty=1 same cycle; no further frame after release.
REQ-032 RS232_TX_PARITY_EN defined, write 0x07 -> parity bit 1; write 0x03 -> parity bit 0; frame 44 cycles.
